bram_sdp: RTL and testbench
===========================

Name: bram_sdp

Overview:
- Simple dual-port block RAM: one write port (port A) and one read port (port B), depth 2**A_WID words of D_WID bits.
- Optional pipelined output register with clock enable.
- Used as the BRAM load element in power/noise stress designs that toggle wide data and alternate addresses every cycle.
- Must infer a single device block RAM with an output register; no logic-built memory.

Parameters:
- A_WID, 9, address width; depth = 2**A_WID.
- D_WID, 72, data word width.
- INIT_VAL, 0, power-up value of every memory word and of the output registers.

Ports:
- wrclk  input  1  write-port clock.
- rdclk  input  1  read-port clock.
- rst  input  1  synchronous active-high reset, sampled on rdclk.
- wraddr  input  A_WID  write address.
- din  input  D_WID  write data.
- we  input  1  write enable.
- porta_en  input  1  write-port enable.
- rdaddr  input  A_WID  read address.
- portb_en  input  1  read-port enable.
- reg_en  input  1  output-register clock enable.
- dout  output  D_WID  read data.
- Clocking: reset rst, synchronous, active-high; clock clk. wrclk and rdclk are both driven from the single system clock clk. All timing below is in clk rising edges.

Behaviour:
- Memory contents:
  - Not affected by rst.
  - Initialised to INIT_VAL at configuration/simulation start.
- Write:
  - On rising wrclk with porta_en=1 and we=1: mem[wraddr] <= din, full width.
  - With porta_en=0 or we=0: no write.
- Read stage 1 (latch):
  - On rising rdclk with rst=1: rd_lat <= 0.
  - Else if portb_en=1: rd_lat <= mem[rdaddr].
  - Else rd_lat holds.
- Read stage 2 (output register, when enabled by the macro):
  - On rising rdclk with rst=1: dout <= 0.
  - Else if reg_en=1: dout <= rd_lat.
  - Else dout holds.
- Latency: rdaddr sampled at edge N appears on dout after edge N+1 (2-cycle latency with the register, reg_en=1).
- Collision: a read and a write to the same address on the same edge return the OLD contents (read-first). The new data is visible to reads issued on later edges.
- Reset:
  - dout = 0 and rd_lat = 0 on the edge after rst is sampled high.
  - rst asserted mid-operation discards in-flight read data and does not corrupt memory.
  - Writes proceed during rst if porta_en and we are high.
- Address wrap-around: none needed; the full 2**A_WID range is addressable with no out-of-range condition.
- No handshake. Enables are level-sensitive per edge.

Optional Feature:
- Macro: BRAM_OUT_REG_EN.
- Defined:
  - Stage-2 output register present, gated by reg_en and reset by rst.
  - Read latency 2 cycles.
- Undefined:
  - dout is driven directly from rd_lat.
  - Read latency 1 cycle.
  - reg_en is ignored (port kept for interface compatibility).

Test Plan:
- Reset: hold rst=1 for 3 cycles with portb_en=1 -> dout=0 throughout and on the first edge after release; memory contents preserved.
- Write/read: porta_en=we=1, write 0xF_FFFF_FFFF at addr 0 and 0 at addr 0x1F. Then read addr 0 and 0x1F with portb_en=reg_en=1 -> dout=0xF_FFFF_FFFF and 0 respectively, 2 cycles after the address (1 cycle without BRAM_OUT_REG_EN).
- Ping-pong: swap wraddr/rdaddr between 0 and 0x1F every cycle while din[35:0] toggles -> each read returns the last completed write to that address; bits [71:36] are never corrupted.
- Collision: write 0xA5 to addr 5 while reading addr 5 on the same edge (old value 0x3C) -> dout shows 0x3C, then 0xA5 on the next read.
- Enables:
  - we=0 or porta_en=0 -> memory unchanged.
  - portb_en=0 -> rd_lat holds.
  - reg_en=0 -> dout holds its last value across at least 4 cycles of changing rdaddr.
- Mid-read reset: assert rst for 1 cycle during a streaming read -> dout=0 on the following edge; correct data resumes 2 cycles after release.

Source files
------------

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port (A), one read port (B), read-first on collision.
// Latency: 2 rdclk edges from rdaddr to dout with BRAM_OUT_REG_EN defined, 1 edge otherwise.
// Backpressure: none; porta_en/we, portb_en and reg_en are level-sensitive per-edge enables.
//
// Ports:
//   wrclk, rdclk : write/read clocks (both tied to the system clock in this codebase)
//   rst          : synchronous active-high reset of the read pipeline, sampled on rdclk
//   wraddr, din, we, porta_en : write port; mem[wraddr] <= din when porta_en && we
//   rdaddr, portb_en          : read port; stage-1 latch loads mem[rdaddr] when portb_en
//   reg_en       : clock enable of the stage-2 output register
//   dout         : read data
// Build option: define BRAM_OUT_REG_EN to add the stage-2 output register.
// Without it dout comes straight from the read latch and reg_en is ignored.

module bram_sdp #(
    parameter int                 A_WID    = 9,
    parameter int                 D_WID    = 72,
    parameter logic [D_WID-1:0]   INIT_VAL = '0
) (
    input  logic             wrclk,
    input  logic             rdclk,
    input  logic             rst,
    input  logic [A_WID-1:0] wraddr,
    input  logic [D_WID-1:0] din,
    input  logic             we,
    input  logic             porta_en,
    input  logic [A_WID-1:0] rdaddr,
    input  logic             portb_en,
    input  logic             reg_en,
    output logic [D_WID-1:0] dout
);

    localparam int DEPTH = 2 ** A_WID;

    // Storage array. Kept free of any reset so it maps onto a device block RAM;
    // the declaration initializer supplies the configuration-time contents.
    logic [D_WID-1:0] r_mem [0:DEPTH-1] = '{default: INIT_VAL};

    // Stage-1 read latch (the block RAM's own output latch).
    logic [D_WID-1:0] r_rd_lat = INIT_VAL;

    // Write port. Memory is untouched by rst, so writes keep going during reset.
    always_ff @(posedge wrclk) begin
        if (porta_en && we) begin
            r_mem[wraddr] <= din;
        end
    end

    // Read port. Non-blocking semantics give read-first behaviour when a write
    // hits the same address on the same edge: the latch captures the old word.
    always_ff @(posedge rdclk) begin
        if (rst) begin
            r_rd_lat <= '0;
        end else if (portb_en) begin
            r_rd_lat <= r_mem[rdaddr];
        end
    end

`ifdef BRAM_OUT_REG_EN
    // Stage-2 output register, absorbed into the block RAM's optional
    // output pipeline register (with its own clock enable and sync reset).
    logic [D_WID-1:0] r_dout = INIT_VAL;

    always_ff @(posedge rdclk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (reg_en) begin
            r_dout <= r_rd_lat;
        end
    end

    assign dout = r_dout;
`else
    // Single-stage read: reg_en stays on the port list for drop-in compatibility.
    logic w_unused_reg_en;
    assign w_unused_reg_en = reg_en;

    assign dout = r_rd_lat;
`endif

endmodule

// File: tb/tb_bram_sdp.sv
// Directed bench for bram_sdp with a behavioural reference model and per-cycle compare.
// Latency: expected read latency follows the BRAM_OUT_REG_EN build option (2 or 1 edges).
// Backpressure: none; stimulus changes on the falling edge, outputs checked on the falling edge.

module tb_bram_sdp;

    localparam int A_WID = 9;
    localparam int D_WID = 72;
    localparam int DEPTH = 2 ** A_WID;
`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk;
    logic             rst;
    logic [A_WID-1:0] wraddr;
    logic [D_WID-1:0] din;
    logic             we;
    logic             porta_en;
    logic [A_WID-1:0] rdaddr;
    logic             portb_en;
    logic             reg_en;
    logic [D_WID-1:0] dout;

    int total = 0;
    int bad   = 0;

    bram_sdp #(
        .A_WID   (A_WID),
        .D_WID   (D_WID),
        .INIT_VAL('0)
    ) dut (
        .wrclk   (clk),
        .rdclk   (clk),
        .rst     (rst),
        .wraddr  (wraddr),
        .din     (din),
        .we      (we),
        .porta_en(porta_en),
        .rdaddr  (rdaddr),
        .portb_en(portb_en),
        .reg_en  (reg_en),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a plain array for the memory, plus the value that
    // the read port has "captured" and the value that is currently visible.
    // ------------------------------------------------------------------
    logic [D_WID-1:0] m_mem [0:DEPTH-1];
    logic [D_WID-1:0] m_captured;
    logic [D_WID-1:0] m_visible;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_captured = '0;
        m_visible  = '0;
    end

    always @(posedge clk) begin
        logic [D_WID-1:0] old_word;
        // A read on this edge sees the contents from before this edge's write.
        old_word = m_mem[rdaddr];
        if (porta_en && we) m_mem[wraddr] = din;
        if (LAT == 2) begin
            if (rst)         m_visible = '0;
            else if (reg_en) m_visible = m_captured;
        end
        if (rst)           m_captured = '0;
        else if (portb_en) m_captured = old_word;
        if (LAT == 1) m_visible = m_captured;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        total++;
        if (dout !== m_visible) begin
            bad++;
            $display("FAIL model_cmp t=%0t dout=%h expected=%h", $time, dout, m_visible);
        end
    end

    task automatic chk(input string nm, input logic [D_WID-1:0] act, input logic [D_WID-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // One full clock: across the rising edge, back to the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a read and check dout once the pipeline has delivered it.
    task automatic rd_chk(input string nm, input logic [A_WID-1:0] a, input logic [D_WID-1:0] exp);
        rdaddr   = a;
        portb_en = 1'b1;
        reg_en   = 1'b1;
        porta_en = 1'b0;
        we       = 1'b0;
        repeat (LAT) cyc();
        chk(nm, dout, exp);
    endtask

    task automatic wr(input logic [A_WID-1:0] a, input logic [D_WID-1:0] d);
        wraddr   = a;
        din      = d;
        porta_en = 1'b1;
        we       = 1'b1;
        cyc();
        porta_en = 1'b0;
        we       = 1'b0;
    endtask

    logic [A_WID-1:0] hold_seq [4];

    initial begin
        rst      = 1'b1;
        wraddr   = 9'd7;
        din      = 72'h777;
        we       = 1'b1;
        porta_en = 1'b1;
        rdaddr   = '0;
        portb_en = 1'b1;
        reg_en   = 1'b1;

        #1 chk("power_up", dout, 72'h0);

        // Reset held 3 cycles while reading; a write proceeds underneath it.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("in_reset", dout, 72'h0);
        end
        rst      = 1'b0;
        porta_en = 1'b0;
        we       = 1'b0;
        cyc();
        chk("after_release", dout, 72'h0);
        rd_chk("write_during_reset", 9'd7, 72'h777);

        // Basic write/read.
        wr(9'h000, 72'hF_FFFF_FFFF);
        wr(9'h01F, 72'h0);
        wr(9'h005, 72'h3C);
        rd_chk("rd_addr0", 9'h000, 72'hF_FFFF_FFFF);
        rd_chk("rd_addr1f", 9'h01F, 72'h0);

        // Write blocked by either enable.
        wraddr = 9'h000; din = 72'hDEAD; porta_en = 1'b1; we = 1'b0; cyc();
        wraddr = 9'h000; din = 72'hBEEF; porta_en = 1'b0; we = 1'b1; cyc();
        rd_chk("no_write_disabled", 9'h000, 72'hF_FFFF_FFFF);

        // Collision: same-address write and read return the old word.
        wraddr = 9'h005; din = 72'hA5; porta_en = 1'b1; we = 1'b1;
        rdaddr = 9'h005; portb_en = 1'b1; reg_en = 1'b1;
        cyc();
        porta_en = 1'b0; we = 1'b0;
        repeat (LAT - 1) cyc();
        chk("collision_old", dout, 72'h3C);
        cyc();
        chk("collision_new", dout, 72'hA5);

        // portb_en=0: read latch holds while the address moves.
        rd_chk("pre_portb_hold", 9'h000, 72'hF_FFFF_FFFF);
        portb_en = 1'b0;
        rdaddr   = 9'h01F;
        repeat (3) cyc();
        chk("portb_hold", dout, 72'hF_FFFF_FFFF);

        // reg_en=0: output register holds across 4 changing addresses.
        rd_chk("pre_reg_hold", 9'h005, 72'hA5);
        hold_seq = '{9'h000, 9'h01F, 9'h007, 9'h000};
        reg_en   = 1'b0;
        portb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdaddr = hold_seq[i];
            cyc();
        end
`ifdef BRAM_OUT_REG_EN
        chk("reg_en_hold", dout, 72'hA5);
`else
        chk("reg_en_ignored", dout, 72'hF_FFFF_FFFF);
`endif
        reg_en = 1'b1;

        // Ping-pong: write and read swap between 0 and 0x1F every cycle.
        porta_en = 1'b1; we = 1'b1; portb_en = 1'b1; reg_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [35:0] lo;
            lo     = 36'(i);
            wraddr = (i % 2 == 1) ? 9'h01F : 9'h000;
            rdaddr = (i % 2 == 1) ? 9'h000 : 9'h01F;
            din    = {36'h5A5A5A5A5, (i % 2 == 1) ? ~lo : lo};
            cyc();
        end
        porta_en = 1'b0; we = 1'b0;
        chk("pingpong_upper", {36'h0, dout[71:36]}, {36'h0, 36'h5A5A5A5A5});
        rd_chk("pingpong_last1f", 9'h01F, {36'h5A5A5A5A5, ~36'd39});

        // Mid-stream reset: one-cycle pulse while streaming reads of addr 5.
        rdaddr = 9'h005; portb_en = 1'b1; reg_en = 1'b1;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        chk("midreset_zero", dout, 72'h0);
        rst = 1'b0;
        repeat (LAT) cyc();
        chk("midreset_resume", dout, 72'hA5);
        rd_chk("mem_survives_reset", 9'h007, 72'h777);

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
